// File: rtl/ctrl_pkg.sv
// Shared control-pipe definitions: branch classes, ALU op classes, opcodes
// and the packed ID/EX control bundle.
package ctrl_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_B    = 2'b01,
    BR_JALR = 2'b10,
    BR_J    = 2'b11
  } br_class_e;

  localparam logic [2:0] ALUOP_ADD   = 3'd0;
  localparam logic [2:0] ALUOP_BR    = 3'd1;
  localparam logic [2:0] ALUOP_R     = 3'd2;
  localparam logic [2:0] ALUOP_I     = 3'd3;
  localparam logic [2:0] ALUOP_LUI   = 3'd4;
  localparam logic [2:0] ALUOP_AUIPC = 3'd5;
  localparam logic [2:0] ALUOP_JUMP  = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       valid;
    logic [2:0] aluop;
    logic       pctoregsrc;
    logic       alusrc;
    logic       rdsrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] branch;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_reg_use_dec.sv
// Register-use decode: which source registers an opcode actually reads.
module reg_use_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       use_rs1_o,
  output logic       use_rs2_o
);

  always_comb begin
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    case (opcode_i)
      OP_R, OP_BRANCH, OP_STORE: begin
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
      end
      OP_LOAD, OP_IMM, OP_JALR: use_rs1_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control pipeline with load-use bubbles, redirect
// squash and mem_busy freeze. Perf counters are built only with CTRL_PERF_EN.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_aluop,
  input  logic              id_pctoregsrc,
  input  logic              id_alusrc,
  input  logic              id_rdsrc,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic [1:0]        id_branch,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              ifid_hold,
  output logic              ex_valid,
  output logic [2:0]        ex_aluop,
  output logic              ex_pctoregsrc,
  output logic              ex_alusrc,
  output logic              ex_rdsrc,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic [1:0]        ex_branch,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_valid,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_memtoreg,
  output logic              mem_regwrite,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_valid,
  output logic              wb_memtoreg,
  output logic              wb_regwrite,
  output logic [REG_AW-1:0] wb_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_t             ex_q, ex_d, id_ctrl;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              mem_valid_q, mem_memread_q, mem_memwrite_q, mem_memtoreg_q, mem_regwrite_q;
  logic              mem_valid_d, mem_memread_d, mem_memwrite_d, mem_memtoreg_d, mem_regwrite_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              wb_valid_q, wb_memtoreg_q, wb_regwrite_q;
  logic              wb_valid_d, wb_memtoreg_d, wb_regwrite_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic              use_rs1, use_rs2, rs_match, load_use;

  reg_use_dec u_reg_use_dec (
    .opcode_i  (id_opcode),
    .use_rs1_o (use_rs1),
    .use_rs2_o (use_rs2)
  );

  always_comb begin
    rs_match = (use_rs1 && (id_rs1 == ex_rd_q)) || (use_rs2 && (id_rs2 == ex_rd_q));
    load_use = ex_q.valid && ex_q.memread && (ex_rd_q != '0) && id_valid && rs_match;
  end

  // A redirect squashes the ID instruction, so holding IF/ID would be pointless.
  assign ifid_hold = mem_busy || (load_use && !ex_redirect);

  always_comb begin
    id_ctrl            = CTRL_BUBBLE;
    id_ctrl.valid      = 1'b1;
    id_ctrl.aluop      = id_aluop;
    id_ctrl.pctoregsrc = id_pctoregsrc;
    id_ctrl.alusrc     = id_alusrc;
    id_ctrl.rdsrc      = id_rdsrc;
    id_ctrl.memread    = id_memread;
    id_ctrl.memwrite   = id_memwrite;
    id_ctrl.memtoreg   = id_memtoreg;
    id_ctrl.regwrite   = id_regwrite && (id_rd != '0);
    id_ctrl.branch     = id_branch;
  end

  always_comb begin
    ex_d           = ex_q;
    ex_rd_d        = ex_rd_q;
    mem_valid_d    = mem_valid_q;
    mem_memread_d  = mem_memread_q;
    mem_memwrite_d = mem_memwrite_q;
    mem_memtoreg_d = mem_memtoreg_q;
    mem_regwrite_d = mem_regwrite_q;
    mem_rd_d       = mem_rd_q;
    wb_valid_d     = wb_valid_q;
    wb_memtoreg_d  = wb_memtoreg_q;
    wb_regwrite_d  = wb_regwrite_q;
    wb_rd_d        = wb_rd_q;
    if (!mem_busy) begin
      wb_valid_d     = mem_valid_q;
      wb_memtoreg_d  = mem_memtoreg_q;
      wb_regwrite_d  = mem_regwrite_q;
      wb_rd_d        = mem_rd_q;
      mem_valid_d    = ex_q.valid;
      mem_memread_d  = ex_q.memread;
      mem_memwrite_d = ex_q.memwrite;
      mem_memtoreg_d = ex_q.memtoreg;
      mem_regwrite_d = ex_q.regwrite;
      mem_rd_d       = ex_rd_q;
      if (ex_redirect || load_use || !id_valid) begin
        ex_d    = CTRL_BUBBLE;
        ex_rd_d = '0;
      end else begin
        ex_d    = id_ctrl;
        ex_rd_d = id_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q           <= CTRL_BUBBLE;
      ex_rd_q        <= '0;
      mem_valid_q    <= 1'b0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_rd_q       <= '0;
      wb_valid_q     <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_rd_q        <= '0;
    end else begin
      ex_q           <= ex_d;
      ex_rd_q        <= ex_rd_d;
      mem_valid_q    <= mem_valid_d;
      mem_memread_q  <= mem_memread_d;
      mem_memwrite_q <= mem_memwrite_d;
      mem_memtoreg_q <= mem_memtoreg_d;
      mem_regwrite_q <= mem_regwrite_d;
      mem_rd_q       <= mem_rd_d;
      wb_valid_q     <= wb_valid_d;
      wb_memtoreg_q  <= wb_memtoreg_d;
      wb_regwrite_q  <= wb_regwrite_d;
      wb_rd_q        <= wb_rd_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_aluop      = ex_q.aluop;
  assign ex_pctoregsrc = ex_q.pctoregsrc;
  assign ex_alusrc     = ex_q.alusrc;
  assign ex_rdsrc      = ex_q.rdsrc;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_memtoreg   = ex_q.memtoreg;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_branch     = ex_q.branch;
  assign ex_rd         = ex_rd_q;
  assign mem_valid     = mem_valid_q;
  assign mem_memread   = mem_memread_q;
  assign mem_memwrite  = mem_memwrite_q;
  assign mem_memtoreg  = mem_memtoreg_q;
  assign mem_regwrite  = mem_regwrite_q;
  assign mem_rd        = mem_rd_q;
  assign wb_valid      = wb_valid_q;
  assign wb_memtoreg   = wb_memtoreg_q;
  assign wb_rd         = wb_rd_q;
  // WB is frozen under mem_busy; masking keeps the commit to the release cycle only.
  assign wb_regwrite   = wb_regwrite_q && !mem_busy;

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    stall_d = ifid_hold ? sat_inc(stall_q) : stall_q;
    flush_d = (ex_redirect && !mem_busy && id_valid) ? sat_inc(flush_q) : flush_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: WB commits are checked against a queue of
// expected results pushed as instructions are accepted into EX.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

`ifdef CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_aluop;
  logic id_pctoregsrc, id_alusrc, id_rdsrc, id_memread, id_memwrite, id_memtoreg, id_regwrite;
  logic [1:0] id_branch;
  logic ex_redirect, mem_busy;
  logic ifid_hold;
  logic ex_valid;
  logic [2:0] ex_aluop;
  logic ex_pctoregsrc, ex_alusrc, ex_rdsrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
  logic [1:0] ex_branch;
  logic [4:0] ex_rd;
  logic mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
  logic [4:0] mem_rd;
  logic wb_valid, wb_memtoreg, wb_regwrite;
  logic [4:0] wb_rd;
  logic [15:0] stall_cnt, flush_cnt;

  ctrl_pipe #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_aluop(id_aluop), .id_pctoregsrc(id_pctoregsrc), .id_alusrc(id_alusrc),
    .id_rdsrc(id_rdsrc), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite), .id_branch(id_branch),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .ifid_hold(ifid_hold),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_pctoregsrc(ex_pctoregsrc),
    .ex_alusrc(ex_alusrc), .ex_rdsrc(ex_rdsrc), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_branch(ex_branch), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
    .wb_rd(wb_rd), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rd;
    logic       rw;
    logic       mtr;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_stall"}, 32'(stall_cnt), PERF ? 32'(exp_stall) : 32'd0);
    chk({tag, "_flush"}, 32'(flush_cnt), PERF ? 32'(exp_flush) : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic rw, input logic mtr);
    exp_t e;
    e.rd  = rd;
    e.rw  = rw && (rd != 5'd0);
    e.mtr = mtr;
    sb_q.push_back(e);
  endtask

  task automatic set_id(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [2:0] alu, input logic mr,
                        input logic mw, input logic mtr, input logic rw, input logic [1:0] br);
    id_valid      = 1'b1;
    id_opcode     = op;
    id_rs1        = rs1;
    id_rs2        = rs2;
    id_rd         = rd;
    id_aluop      = alu;
    id_pctoregsrc = (br == BR_J) || (br == BR_JALR);
    id_alusrc     = (op != OP_R) && (op != OP_BRANCH);
    id_rdsrc      = 1'b0;
    id_memread    = mr;
    id_memwrite   = mw;
    id_memtoreg   = mtr;
    id_regwrite   = rw;
    id_branch     = br;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_opcode = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_aluop = '0; id_pctoregsrc = 1'b0; id_alusrc = 1'b0; id_rdsrc = 1'b0;
    id_memread = 1'b0; id_memwrite = 1'b0; id_memtoreg = 1'b0; id_regwrite = 1'b0;
    id_branch = '0;
  endtask

  // WB commit monitor: one pop per committed WB cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_valid === 1'b1 && mem_busy === 1'b0) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_regwrite", 32'(wb_regwrite), 32'(e.rw));
        chk("wb_memtoreg", 32'(wb_memtoreg), 32'(e.mtr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_busy = 1'b0; ex_redirect = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_regwrite", 32'(wb_regwrite), 0);
    chk("rst_hold", 32'(ifid_hold), 0);
    chk_cnt("rst");
    rst_n = 1'b1;

    // lw x5 then add x6,x5,x7: one-cycle load-use hold
    set_id(OP_LOAD, 5'd1, 5'd0, 5'd5, ALUOP_ADD, 1, 0, 1, 1, BR_NONE);
    #1 chk("t1_lw_hold", 32'(ifid_hold), 0);
    push(5'd5, 1, 1);
    tick();
    set_id(OP_R, 5'd5, 5'd7, 5'd6, ALUOP_R, 0, 0, 0, 1, BR_NONE);
    #1 chk("t1_hold", 32'(ifid_hold), 1);
    chk("t1_ex_memread", 32'(ex_memread), 1);
    chk("t1_ex_alusrc", 32'(ex_alusrc), 1);
    exp_stall++;
    tick();
    chk("t1_bubble", 32'(ex_valid), 0);
    chk("t1_hold_rel", 32'(ifid_hold), 0);
    push(5'd6, 1, 0);
    tick();
    chk("t1_add_valid", 32'(ex_valid), 1);
    chk("t1_add_rd", 32'(ex_rd), 6);
    chk("t1_add_rw", 32'(ex_regwrite), 1);
    chk("t1_add_aluop", 32'(ex_aluop), 32'(ALUOP_R));
    idle();
    chk_cnt("t1");
    repeat (4) tick();

    // lw x5 then addi x6,x0,1 (rs2 field = 5 but unused); lw x0 then add x1,x0,x0
    set_id(OP_LOAD, 5'd1, 5'd0, 5'd5, ALUOP_ADD, 1, 0, 1, 1, BR_NONE);
    push(5'd5, 1, 1);
    tick();
    set_id(OP_IMM, 5'd0, 5'd5, 5'd6, ALUOP_I, 0, 0, 0, 1, BR_NONE);
    #1 chk("t2_addi_hold", 32'(ifid_hold), 0);
    push(5'd6, 1, 0);
    tick();
    set_id(OP_LOAD, 5'd5, 5'd0, 5'd0, ALUOP_ADD, 1, 0, 1, 1, BR_NONE);
    push(5'd0, 1, 1);
    tick();
    set_id(OP_R, 5'd0, 5'd0, 5'd1, ALUOP_R, 0, 0, 0, 1, BR_NONE);
    #1 chk("t2_x0_hold", 32'(ifid_hold), 0);
    push(5'd1, 1, 0);
    tick();
    chk("t2_add_valid", 32'(ex_valid), 1);
    chk("t2_add_rd", 32'(ex_rd), 1);
    chk("t2_x0_mem_rw", 32'(mem_regwrite), 0);
    chk("t2_x0_mem_mr", 32'(mem_memread), 1);
    idle();
    repeat (4) tick();

    // beq in EX redirects while sw sits in ID
    set_id(OP_BRANCH, 5'd1, 5'd2, 5'd0, ALUOP_BR, 0, 0, 0, 0, BR_B);
    push(5'd0, 0, 0);
    tick();
    chk("t3_ex_branch", 32'(ex_branch), 32'(BR_B));
    set_id(OP_STORE, 5'd2, 5'd3, 5'd0, ALUOP_ADD, 0, 1, 0, 0, BR_NONE);
    ex_redirect = 1'b1;
    #1 chk("t3_hold", 32'(ifid_hold), 0);
    exp_flush++;
    tick();
    chk("t3_ex_valid", 32'(ex_valid), 0);
    chk("t3_ex_memwrite", 32'(ex_memwrite), 0);
    chk_cnt("t3");
    ex_redirect = 1'b0;
    idle();
    repeat (4) tick();

    // redirect and load-use in the same cycle
    set_id(OP_LOAD, 5'd1, 5'd0, 5'd5, ALUOP_ADD, 1, 0, 1, 1, BR_NONE);
    push(5'd5, 1, 1);
    tick();
    set_id(OP_R, 5'd5, 5'd7, 5'd6, ALUOP_R, 0, 0, 0, 1, BR_NONE);
    ex_redirect = 1'b1;
    #1 chk("t4_hold", 32'(ifid_hold), 0);
    exp_flush++;
    tick();
    chk("t4_ex_valid", 32'(ex_valid), 0);
    chk_cnt("t4");
    ex_redirect = 1'b0;
    idle();
    repeat (4) tick();

    // mem_busy for 3 cycles with addi x9 in WB; redirect during busy is ignored
    set_id(OP_IMM, 5'd0, 5'd0, 5'd9, ALUOP_I, 0, 0, 0, 1, BR_NONE);
    push(5'd9, 1, 0);
    tick();
    idle();
    tick();
    tick();
    chk("t5_wb_valid", 32'(wb_valid), 1);
    chk("t5_wb_rd", 32'(wb_rd), 9);
    mem_busy = 1'b1;
    set_id(OP_R, 5'd1, 5'd2, 5'd10, ALUOP_R, 0, 0, 0, 1, BR_NONE);
    ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_busy_wb_rw", 32'(wb_regwrite), 0);
      chk("t5_busy_wb_rd", 32'(wb_rd), 9);
      chk("t5_busy_hold", 32'(ifid_hold), 1);
      chk("t5_busy_ex_valid", 32'(ex_valid), 0);
      exp_stall++;
      tick();
    end
    mem_busy = 1'b0;
    ex_redirect = 1'b0;
    push(5'd10, 1, 0);
    #1;
    chk("t5_rel_wb_rw", 32'(wb_regwrite), 1);
    chk("t5_rel_wb_rd", 32'(wb_rd), 9);
    chk("t5_rel_hold", 32'(ifid_hold), 0);
    chk_cnt("t5");
    tick();
    chk("t5_ex_valid", 32'(ex_valid), 1);
    chk("t5_ex_rd", 32'(ex_rd), 10);
    idle();
    repeat (4) tick();

    // async reset with all stages valid
    set_id(OP_IMM, 5'd0, 5'd0, 5'd11, ALUOP_I, 0, 0, 0, 1, BR_NONE);
    push(5'd11, 1, 0);
    tick();
    set_id(OP_IMM, 5'd0, 5'd0, 5'd12, ALUOP_I, 0, 0, 0, 1, BR_NONE);
    push(5'd12, 1, 0);
    tick();
    set_id(OP_STORE, 5'd1, 5'd2, 5'd0, ALUOP_ADD, 0, 1, 0, 0, BR_NONE);
    push(5'd0, 0, 0);
    tick();
    idle();
    chk("t6_pre_ex_valid", 32'(ex_valid), 1);
    chk("t6_pre_mem_valid", 32'(mem_valid), 1);
    chk("t6_pre_wb_valid", 32'(wb_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_ex_valid", 32'(ex_valid), 0);
    chk("t6_ex_memwrite", 32'(ex_memwrite), 0);
    chk("t6_mem_valid", 32'(mem_valid), 0);
    chk("t6_mem_regwrite", 32'(mem_regwrite), 0);
    chk("t6_wb_valid", 32'(wb_valid), 0);
    chk("t6_wb_regwrite", 32'(wb_regwrite), 0);
    exp_stall = 0;
    exp_flush = 0;
    chk_cnt("t6");
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    set_id(OP_IMM, 5'd0, 5'd0, 5'd14, ALUOP_I, 0, 0, 0, 1, BR_NONE);
    push(5'd14, 1, 0);
    tick();
    idle();
    repeat (5) tick();
    chk("sb_left", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
